// File: rtl/imc_in_collector.sv
// imc_in_collector: gathers NUM_WORDS words of DATA_W bits from a valid/ready
// stream into one vector. When the vector is full and the IMC reports ready,
// it issues a one-cycle start pulse.
//
// Optional build macro IMC_IN_STALL_CNT_EN: adds stall_cnt_o, a saturating
// count of cycles spent waiting for the IMC. Only rstn_i clears it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no partial vector; the next accept is slot 0
// COLLECT  | partial vector held; accepting further words
// WAIT_IMC | vector complete; upstream stalled until imc_ready_i
// START    | start pulse to the IMC; returns to IDLE next cycle

module imc_in_collector #(
    parameter int  DATA_W    = 8,
    parameter int  NUM_WORDS = 4,
    localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        clear_i,
    input  logic [DATA_W-1:0]           data_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic                        imc_ready_i,
    output logic                        imc_start_o,
    output logic [NUM_WORDS*DATA_W-1:0] imc_data_o,
    output logic [CNT_W-1:0]            word_cnt_o,
    output logic                        busy_o
`ifdef IMC_IN_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        WAIT_IMC = 2'd2,
        START    = 2'd3
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [NUM_WORDS*DATA_W-1:0] data_q;
    logic                        accept;
    logic                        last_word;

    assign data_ready_o = (state_q == IDLE) || (state_q == COLLECT);
    // clear_i blocks the accept so that an aborted cycle never writes a slot.
    assign accept       = data_valid_i && data_ready_o && !clear_i;
    // In IDLE the count is 0, so NUM_WORDS == 1 completes on the first accept.
    assign last_word    = (cnt_q == CNT_W'(NUM_WORDS - 1));

    assign imc_start_o  = (state_q == START);
    assign busy_o       = (state_q != IDLE);
    assign imc_data_o   = data_q;
    assign word_cnt_o   = cnt_q;

    // State and word-count registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and next-count decode; clear_i overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = imc_ready_i ? START : WAIT_IMC;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            WAIT_IMC: begin
                if (imc_ready_i) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // Vector register: an accepted word lands in the slot given by the count.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q <= '0;
        end else begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                if (accept && (cnt_q == CNT_W'(i))) begin
                    data_q[i*DATA_W +: DATA_W] <= data_i;
                end
            end
        end
    end

`ifdef IMC_IN_STALL_CNT_EN
    logic [15:0] stall_q;

    assign stall_cnt_o = stall_q;

    // Saturating count of WAIT_IMC cycles; an abort does not clear it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_q <= '0;
        end else if ((state_q == WAIT_IMC) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imc_in_collector.sv
// Directed bench for imc_in_collector. It drives a NUM_WORDS=4 instance from a
// per-cycle vector table and a NUM_WORDS=1 instance by hand. It also runs a
// hand sequence for an asynchronous reset in the middle of a vector.

module tb_imc_in_collector;

    typedef struct {
        logic        clr;
        logic        vld;
        logic [7:0]  d;
        logic        rdy;
        logic        e_ready;
        logic        e_start;
        logic [2:0]  e_cnt;
        logic        e_busy;
        logic [31:0] e_data;
    } vec_t;

    logic        clk;
    logic        rstn;
    logic        clr, vld, rdy;
    logic [7:0]  d;
    logic        ready, start, busy;
    logic [31:0] data;
    logic [2:0]  cnt;

    logic        u1_vld, u1_rdy;
    logic [7:0]  u1_d;
    logic        u1_ready, u1_start, u1_busy;
    logic [7:0]  u1_data;
    logic [0:0]  u1_cnt;

`ifdef IMC_IN_STALL_CNT_EN
    logic [15:0] stall, u1_stall;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    int   stall_row = -1;
    vec_t tbl[$];

    imc_in_collector #(.DATA_W(8), .NUM_WORDS(4)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .clear_i      (clr),
        .data_i       (d),
        .data_valid_i (vld),
        .data_ready_o (ready),
        .imc_ready_i  (rdy),
        .imc_start_o  (start),
        .imc_data_o   (data),
        .word_cnt_o   (cnt),
        .busy_o       (busy)
`ifdef IMC_IN_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall)
`endif
    );

    imc_in_collector #(.DATA_W(8), .NUM_WORDS(1)) dut1 (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .clear_i      (1'b0),
        .data_i       (u1_d),
        .data_valid_i (u1_vld),
        .data_ready_o (u1_ready),
        .imc_ready_i  (u1_rdy),
        .imc_start_o  (u1_start),
        .imc_data_o   (u1_data),
        .word_cnt_o   (u1_cnt),
        .busy_o       (u1_busy)
`ifdef IMC_IN_STALL_CNT_EN
        ,
        .stall_cnt_o  (u1_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic v, input logic [7:0] dd, input logic r,
                       input logic er, input logic es, input logic [2:0] ec,
                       input logic eb, input logic [31:0] ed);
        vec_t x;
        x.clr = c; x.vld = v; x.d = dd; x.rdy = r;
        x.e_ready = er; x.e_start = es; x.e_cnt = ec; x.e_busy = eb; x.e_data = ed;
        tbl.push_back(x);
    endtask

    task automatic chk_main(input string tag, input logic er, input logic es,
                            input logic [2:0] ec, input logic eb, input logic [31:0] ed);
        chk({tag, " ready"}, {31'd0, ready}, {31'd0, er});
        chk({tag, " start"}, {31'd0, start}, {31'd0, es});
        chk({tag, " cnt"},   {29'd0, cnt},   {29'd0, ec});
        chk({tag, " busy"},  {31'd0, busy},  {31'd0, eb});
        chk({tag, " data"},  data,           ed);
    endtask

    initial begin
        // Inputs: clr, vld, d, rdy. Expected: ready, start, cnt, busy, data.
        // Expected values describe the state before the row's clock edge.
        // Back-to-back vector, IMC ready.
        add(0,1,8'h11,1, 1,0,0,0,32'h00000000);
        add(0,1,8'h22,1, 1,0,1,1,32'h00000011);
        add(0,1,8'h33,1, 1,0,2,1,32'h00002211);
        add(0,1,8'h44,1, 1,0,3,1,32'h00332211);
        add(0,1,8'h55,1, 0,1,4,1,32'h44332211);
        add(0,0,8'h00,1, 1,0,0,0,32'h44332211);
        // IMC not ready: 10 WAIT_IMC cycles with a 5th word offered.
        add(0,1,8'hA1,0, 1,0,0,0,32'h44332211);
        add(0,1,8'hB2,0, 1,0,1,1,32'h443322A1);
        add(0,1,8'hC3,0, 1,0,2,1,32'h4433B2A1);
        add(0,1,8'hD4,0, 1,0,3,1,32'h44C3B2A1);
        for (int i = 0; i < 9; i++) add(0,1,8'hE5,0, 0,0,4,1,32'hD4C3B2A1);
        add(0,1,8'hE5,1, 0,0,4,1,32'hD4C3B2A1);
        stall_row = tbl.size();
        add(0,0,8'h00,1, 0,1,4,1,32'hD4C3B2A1);
        add(0,0,8'h00,1, 1,0,0,0,32'hD4C3B2A1);
        // Valid pattern 1,0,0,1,1,0,1.
        add(0,1,8'h0A,1, 1,0,0,0,32'hD4C3B2A1);
        add(0,0,8'hFF,1, 1,0,1,1,32'hD4C3B20A);
        add(0,0,8'hFF,1, 1,0,1,1,32'hD4C3B20A);
        add(0,1,8'h0B,1, 1,0,1,1,32'hD4C3B20A);
        add(0,1,8'h0C,1, 1,0,2,1,32'hD4C30B0A);
        add(0,0,8'hFF,1, 1,0,3,1,32'hD40C0B0A);
        add(0,1,8'h0D,1, 1,0,3,1,32'hD40C0B0A);
        add(0,0,8'h00,1, 0,1,4,1,32'h0D0C0B0A);
        add(0,0,8'h00,1, 1,0,0,0,32'h0D0C0B0A);
        // Clear after two accepts, then a full new vector.
        add(0,1,8'hE1,1, 1,0,0,0,32'h0D0C0B0A);
        add(0,1,8'hE2,1, 1,0,1,1,32'h0D0C0BE1);
        add(1,1,8'hE3,1, 1,0,2,1,32'h0D0CE2E1);
        add(0,1,8'h55,1, 1,0,0,0,32'h0D0CE2E1);
        add(0,1,8'h66,1, 1,0,1,1,32'h0D0CE255);
        add(0,1,8'h77,1, 1,0,2,1,32'h0D0C6655);
        add(0,1,8'h88,1, 1,0,3,1,32'h0D776655);
        add(0,0,8'h00,1, 0,1,4,1,32'h88776655);
        add(0,0,8'h00,1, 1,0,0,0,32'h88776655);
        // Clear while in WAIT_IMC.
        add(0,1,8'h01,0, 1,0,0,0,32'h88776655);
        add(0,1,8'h02,0, 1,0,1,1,32'h88776601);
        add(0,1,8'h03,0, 1,0,2,1,32'h88770201);
        add(0,1,8'h04,0, 1,0,3,1,32'h88030201);
        add(1,0,8'h00,0, 0,0,4,1,32'h04030201);
        add(0,0,8'h00,1, 1,0,0,0,32'h04030201);
        // Clear during START: the pulse still goes out.
        add(0,1,8'h10,1, 1,0,0,0,32'h04030201);
        add(0,1,8'h20,1, 1,0,1,1,32'h04030210);
        add(0,1,8'h30,1, 1,0,2,1,32'h04032010);
        add(0,1,8'h40,1, 1,0,3,1,32'h04302010);
        add(1,1,8'h50,1, 0,1,4,1,32'h40302010);
        add(0,0,8'h00,1, 1,0,0,0,32'h40302010);

        clr = 0; vld = 0; d = '0; rdy = 0;
        u1_vld = 0; u1_d = '0; u1_rdy = 0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk_main("reset", 1, 0, 0, 0, 32'h0);
        chk("reset u1 start", {31'd0, u1_start}, 32'd0);
        chk("reset u1 data",  {24'd0, u1_data},  32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            clr = tbl[i].clr; vld = tbl[i].vld; d = tbl[i].d; rdy = tbl[i].rdy;
            #1;
            chk_main($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_start,
                     tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_data);
`ifdef IMC_IN_STALL_CNT_EN
            if (i == stall_row) chk("stall cnt", {16'd0, stall}, 32'd10);
`endif
        end

        // Asynchronous reset with three words held.
        @(negedge clk); clr = 0; vld = 1; d = 8'h01; rdy = 1;
        @(negedge clk); d = 8'h02;
        @(negedge clk); d = 8'h03;
        @(negedge clk); vld = 0;
        #1;
        chk_main("pre-rst", 1, 0, 3, 1, 32'h40030201);
        rstn = 1'b0;
        #1;
        chk_main("async rst", 1, 0, 0, 0, 32'h0);
        @(negedge clk); rstn = 1'b1; vld = 1; d = 8'h77;
        @(negedge clk); vld = 0;
        #1;
        chk_main("post-rst", 1, 0, 1, 1, 32'h00000077);

        // NUM_WORDS=1: a single word completes the vector.
        @(negedge clk); u1_vld = 1; u1_d = 8'h5A; u1_rdy = 1;
        #1;
        chk("u1 idle ready", {31'd0, u1_ready}, 32'd1);
        chk("u1 idle start", {31'd0, u1_start}, 32'd0);
        @(negedge clk); u1_vld = 0;
        #1;
        chk("u1 start",       {31'd0, u1_start}, 32'd1);
        chk("u1 start ready", {31'd0, u1_ready}, 32'd0);
        chk("u1 start cnt",   {31'd0, u1_cnt},   32'd1);
        chk("u1 data",        {24'd0, u1_data},  32'h5A);
        @(negedge clk);
        #1;
        chk("u1 after start", {31'd0, u1_start}, 32'd0);
        chk("u1 after busy",  {31'd0, u1_busy},  32'd0);
        chk("u1 after cnt",   {31'd0, u1_cnt},   32'd0);
        chk("u1 after data",  {24'd0, u1_data},  32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
